// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary-to-BCD converter using shift-and-add-3, one input bit per clock.
// Latency: done pulses WIDTH cycles after the accepting edge; one conversion per WIDTH+1 cycles sustained.
// Backpressure: in_ready is high only while idle; in_valid is ignored during a conversion.
// Ports: clk/rst_n (sync, active-low); in_valid/in_ready/in_data request handshake;
//        done (1-cycle result strobe), bcd (digit 0 = units), overflow (saturated to all 9s),
//        blank (leading-zero mask, bit 0 never set).
module bin2bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  in_ready,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow,
  output logic [DIGITS-1:0]     blank
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int SW = 4 * DIGITS;
  localparam logic [CW-1:0]     CNT_INIT  = CW'(WIDTH);
  localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t            r_state, w_state_nxt;
  logic [CW-1:0]     r_cnt;
  logic [SW-1:0]     r_scr;
  logic [WIDTH-1:0]  r_sh;
  logic              r_ovf_scr;
  logic [SW-1:0]     r_bcd;
  logic              r_ovf;
  logic [DIGITS-1:0] r_blank;
  logic              r_done;

  logic              w_accept;
  logic              w_last;
  logic [SW-1:0]     w_adj;
  logic [SW+WIDTH-1:0] w_cat;
  logic [SW-1:0]     w_scr_nxt;
  logic [WIDTH-1:0]  w_sh_nxt;
  logic              w_ovf_nxt;
  logic [DIGITS-1:0] w_blank;

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next-state and control strobes
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (r_cnt == CW'(1)) begin
          w_last      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Add-3 correction per digit, then one left shift of {scratch, binary}.
  always_comb begin
    w_adj = r_scr;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_scr[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_scr[4*i +: 4] + 4'd3;
    end
  end

  assign w_cat     = {w_adj, r_sh} << 1;
  assign w_scr_nxt = w_cat[SW+WIDTH-1:WIDTH];
  assign w_sh_nxt  = w_cat[WIDTH-1:0];
  // A bit leaving the top digit means the value needs more digits than we have.
  assign w_ovf_nxt = r_ovf_scr | w_adj[SW-1];

  // blank[i] is set when digit i and every digit above it are zero.
  always_comb begin
    logic v_all_zero;
    w_blank    = '0;
    v_all_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      v_all_zero = v_all_zero & (w_scr_nxt[4*i +: 4] == 4'd0);
      w_blank[i] = v_all_zero;
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_scr     <= '0;
      r_sh      <= '0;
      r_ovf_scr <= 1'b0;
      r_bcd     <= '0;
      r_ovf     <= 1'b0;
      r_blank   <= BLANK_RST;
      r_done    <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_accept) begin
        r_sh      <= in_data;
        r_scr     <= '0;
        r_ovf_scr <= 1'b0;
        r_cnt     <= CNT_INIT;
      end else if (r_state == S_SHIFT) begin
        r_scr     <= w_scr_nxt;
        r_sh      <= w_sh_nxt;
        r_ovf_scr <= w_ovf_nxt;
        r_cnt     <= r_cnt - CW'(1);
        if (w_last) begin
          if (w_ovf_nxt) begin
            r_bcd   <= {DIGITS{4'd9}};
            r_ovf   <= 1'b1;
            r_blank <= '0;
          end else begin
            r_bcd   <= w_scr_nxt;
            r_ovf   <= 1'b0;
            r_blank <= w_blank;
          end
        end
      end
    end
  end

  assign in_ready = (r_state == S_IDLE);
  assign done     = r_done;
  assign bcd      = r_bcd;
  assign overflow = r_ovf;
  assign blank    = r_blank;

endmodule
